serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits; legal range 1..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL indicate that op_a, op_b and c_in are valid.
REQ-005 in_ready  output  1  SHALL indicate that the block can accept an operand pair.
REQ-006 op_a  input  WIDTH  SHALL be operand A.
REQ-007 op_b  input  WIDTH  SHALL be operand B.
REQ-008 c_in  input  1  SHALL be the carry-in.
REQ-009 out_valid  output  1  SHALL indicate that sum and c_out hold a completed result.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011 sum  output  WIDTH  SHALL be the result, (op_a + op_b + c_in) mod 2^WIDTH.
REQ-012 c_out  output  1  SHALL be bit WIDTH of op_a + op_b + c_in.

Function
REQ-013 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, through one single-bit full-adder cell.
- Cell outputs: sum bit = a^b^c; carry = majority(a,b,c).
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In IDLE, an input handshake (in_valid & in_ready) SHALL load op_a and op_b into shift registers, load c_in into the carry register, clear the bit counter and enter SHIFT.
REQ-017 In SHIFT, in_ready SHALL be 0, and each cycle SHALL perform the following:
- apply the operand LSBs and the carry register to the cell;
- shift the cell sum bit into the MSB of the sum register and shift the operands right;
- register the cell carry;
- increment the counter.
REQ-018 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
- out_valid SHALL be high in the cycle following the WIDTH-th SHIFT edge.
- Latency from the accepting edge to the out_valid-visible cycle is WIDTH cycles.
REQ-019 In DONE, out_valid SHALL be 1, and sum and c_out SHALL hold stable until out_ready is sampled 1.
- On that edge, the FSM SHALL return to IDLE.
- There is no same-cycle bypass to a new load.
REQ-020 in_valid asserted in SHIFT or DONE SHALL be ignored, with no state change.
REQ-021 out_ready held 1 continuously SHALL give one result per WIDTH+2 cycles.
REQ-022 sum and c_out SHALL hold the last result after returning to IDLE, until the next completion overwrites them.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap.
REQ-024 WIDTH=1 SHALL work: one SHIFT cycle, then DONE.

Reset
REQ-025 rst_n low SHALL immediately force the following, regardless of clk:
- FSM to IDLE;
- sum, c_out, carry register, counter and shift registers to 0;
- out_valid to 0 and in_ready to 1.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no result emitted.
- After deassertion, the next accepted operand pair SHALL complete normally.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT, DONE);
- the WIDTH default;
- a function returning the counter width.
REQ-028 The single-bit full adder SHALL be a separate sub-module fa_cell (inputs a, b, c; outputs s, co), purely combinational and instantiated once.
REQ-029 All registers SHALL reside in serial_adder; fa_cell SHALL contain no state.

Verification
REQ-030 WIDTH=8, op_a=0x5A, op_b=0x3C, c_in=0 -> sum=0x96, c_out=0, out_valid exactly 8 cycles after the accepting edge.
REQ-031 WIDTH=8, op_a=0xFF, op_b=0x01, c_in=0 -> sum=0x00, c_out=1; and op_a=0xFF, op_b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-032 Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum and c_out stable, in_ready=0; in_valid pulses during SHIFT and DONE are ignored.
REQ-033 rst_n pulsed low at SHIFT cycle 4 -> out_valid never rises for that pair, all outputs 0 at once; next pair 0x10+0x20+0 -> sum=0x30, c_out=0.
REQ-034 WIDTH=1, a=1, b=1, c_in=1 -> sum=1, c_out=1 after 1 cycle; back-to-back stream of 100 random pairs with out_ready=1 -> all results match a reference model, one per WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // The counter must be able to hold WIDTH itself, so it never wraps.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used once by serial_adder; purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand pair, adds it LSB first through one
// full-adder cell over WIDTH cycles, then holds the result until consumed.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c_out;
   logic [CNT_W-1:0] r_cnt;
   logic             w_s;
   logic             w_co;
   logic             w_load;
   logic             w_shift;
   logic             w_last;
   logic [WIDTH:0]   w_acc_cat;

   fa_cell u_fa (
      .a  (r_a[0]),
      .b  (r_b[0]),
      .c  (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last    = (r_cnt == LAST_CNT);
   // Concatenation then slice keeps the shift legal even when WIDTH is 1.
   assign w_acc_cat = {w_s, r_acc};

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load       = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            w_shift = 1'b1;
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= c_in;
            r_cnt   <= '0;
         end else if (w_shift) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_co;
            r_acc   <= w_acc_cat[WIDTH:1];
            r_cnt   <= r_cnt + CNT_W'(1);
            // Visible result only changes on completion, so it survives the next operation.
            if (w_last) begin
               r_sum   <= w_acc_cat[WIDTH:1];
               r_c_out <= w_co;
            end
         end
      end
   end

   assign sum   = r_sum;
   assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random/reset cases
// and a WIDTH=1 back-to-back stream, both against an arithmetic reference.
module tb_serial_adder;

   localparam int W8 = 8;
   localparam int W1 = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic          in_valid, in_ready, c_in, out_valid, out_ready, c_out;
   logic [W8-1:0] op_a, op_b, sum;

   logic          in_valid_1, in_ready_1, c_in_1, out_valid_1, out_ready_1, c_out_1;
   logic [W1-1:0] op_a_1, op_b_1, sum_1;

   serial_adder #(.WIDTH(W8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
   );

   serial_adder #(.WIDTH(W1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_1),
      .in_ready  (in_ready_1),
      .op_a      (op_a_1),
      .op_b      (op_b_1),
      .c_in      (c_in_1),
      .out_valid (out_valid_1),
      .out_ready (out_ready_1),
      .sum       (sum_1),
      .c_out     (c_out_1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic wait_ready8();
      int k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("in_ready8_wait", in_ready, 1);
   endtask

   // One full WIDTH=8 transaction with optional back-pressure and in_valid noise.
   task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic ci,
                       input int hold, input bit noise);
      logic [W8:0] exp;
      int cnt;
      exp = 9'(a) + 9'(b) + 9'(ci);
      wait_ready8();
      op_a     = a;
      op_b     = b;
      c_in     = ci;
      in_valid = 1'b1;
      cnt = 0;
      while (cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) begin
            check("busy_in_ready", in_ready, 0);
            in_valid = noise;
            op_a     = 8'($urandom);
         end else begin
            in_valid = noise & ~in_valid;
         end
         if (out_valid) break;
      end
      check("out_valid_rise", out_valid, 1);
      check("latency", 64'(cnt - 1), 64'(W8));
      check("sum", sum, exp[W8-1:0]);
      check("c_out", c_out, exp[W8]);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = noise & ~in_valid;
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_sum", sum, exp[W8-1:0]);
         check("hold_c_out", c_out, exp[W8]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_sum_kept", sum, exp[W8-1:0]);
      check("idle_c_out_kept", c_out, exp[W8]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] e1;
      int prev_cyc;
      int acc_cyc;
      int k;

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      op_a        = '0;
      op_b        = '0;
      c_in        = 1'b0;
      out_ready   = 1'b0;
      in_valid_1  = 1'b0;
      op_a_1      = '0;
      op_b_1      = '0;
      c_in_1      = 1'b0;
      out_ready_1 = 1'b0;
      prev_cyc    = 0;

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sum", sum, 0);
      check("rst_c_out", c_out, 0);
      check("rst1_out_valid", out_valid_1, 0);
      check("rst1_in_ready", in_ready_1, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1, 1'b0);
      run8(8'hFF, 8'hFF, 1'b1, 5, 1'b1);
      run8(8'h00, 8'h00, 1'b0, 2, 1'b1);
      for (int i = 0; i < 20; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      run8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);

      // Abort an operation in its 4th SHIFT cycle.
      wait_ready8();
      op_a     = 8'hAB;
      op_b     = 8'hCD;
      c_in     = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_sum", sum, 0);
      check("abort_c_out", c_out, 0);
      repeat (2) @(negedge clk);
      check("abort_hold_valid", out_valid, 0);
      rst_n = 1'b1;
      for (int i = 0; i < W8 + 4; i++) begin
         @(negedge clk);
         check("abort_no_result", out_valid, 0);
      end
      run8(8'h10, 8'h20, 1'b0, 0, 1'b0);

      // WIDTH=1 back-to-back stream, first pair directed 1+1+1.
      out_ready_1 = 1'b1;
      op_a_1      = 1'b1;
      op_b_1      = 1'b1;
      c_in_1      = 1'b1;
      in_valid_1  = 1'b1;
      for (int i = 0; i < 101; i++) begin
         k = 0;
         while (!in_ready_1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("w1_in_ready", in_ready_1, 1);
         acc_cyc = cyc;
         if (i > 0) check("w1_period", 64'(acc_cyc - prev_cyc), 64'(W1 + 2));
         prev_cyc = acc_cyc;
         e1 = 2'(op_a_1) + 2'(op_b_1) + 2'(c_in_1);
         k = 0;
         while (k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
               check("w1_busy", in_ready_1, 0);
               op_a_1 = 1'($urandom);
               op_b_1 = 1'($urandom);
               c_in_1 = 1'($urandom);
            end
            if (out_valid_1) break;
         end
         check("w1_out_valid", out_valid_1, 1);
         check("w1_latency", 64'(k - 1), 64'(W1));
         check("w1_sum", sum_1, e1[0]);
         check("w1_c_out", c_out_1, e1[1]);
      end
      in_valid_1 = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
